link_rx_buffer: RTL and testbench

Receiving end of the four-phase req/ack byte link driven by the link master. It responds to each request with an acknowledge and captures the presented byte into a small show-ahead FIFO. A downstream consumer drains the FIFO through a valid/ready read port. It counts bytes into fixed-length frames and pulses `frame_done` when a frame completes; when the FIFO is full it stalls the link by withholding `ack_out`.

---
 rtl/link_rx_buffer.sv | 135 +++++++++++++
 tb/tb_link_rx_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/link_rx_buffer.sv
// Four-phase req/ack link receiver with show-ahead FIFO and frame counter; optional `LINK_RX_REQ_SYNC_EN` req synchronizer.
// Latency: ack/push 1 cycle after req seen high (3 with sync); release 1 cycle (3 with sync). Full FIFO withholds ack.
module link_rx_buffer #(
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_in,
    input  logic [7:0]                   data_in,
    output logic                         ack_out,
    output logic [7:0]                   last_byte_out,
    output logic                         rd_valid,
    output logic [7:0]                   rd_data,
    input  logic                         rd_ready,
    output logic [$clog2(DEPTH):0]       level_out,
    output logic [$clog2(FRAME_LEN):0]   byte_cnt_out,
    output logic                         frame_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FRAME_LEN) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_LEN - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t          state_q, state_d;
    logic            req_s;
    logic            push, pop, full;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      last_q, last_d;
    logic            fd_q, fd_d;

`ifdef LINK_RX_REQ_SYNC_EN
    logic req_meta_q, req_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_meta_q <= 1'b0;
            req_sync_q <= 1'b0;
        end else begin
            req_meta_q <= req_in;
            req_sync_q <= req_meta_q;
        end
    end

    assign req_s = req_sync_q;
`else
    assign req_s = req_in;
`endif

    // Full test uses the registered level, so a same-cycle pop cannot admit a push.
    assign full     = (level_q == LVL_FULL);
    assign rd_valid = (level_q != '0);
    assign pop      = rd_valid && rd_ready;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s && !full) begin
                    push    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        fd_d     = 1'b0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            last_d   = data_in;
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                fd_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            last_q   <= 8'h00;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            fd_q     <= fd_d;
        end
    end

    // Storage needs no reset: the level gates what is visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    assign ack_out       = (state_q == ACK);
    assign last_byte_out = last_q;
    assign rd_data       = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign level_out     = level_q;
    assign byte_cnt_out  = cnt_q;
    assign frame_done    = fd_q;

endmodule

// File: tb/tb_link_rx_buffer.sv
// Bench for link_rx_buffer: directed handshakes plus a random four-phase master, checked against a queue-based model.
module tb_link_rx_buffer;
    localparam int DEPTH = 4;
    localparam int FL    = 4;

    logic       clk;
    logic       rst;
    logic       req_in;
    logic [7:0] data_in;
    logic       ack_out;
    logic [7:0] last_byte_out;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic [2:0] level_out;
    logic [2:0] byte_cnt_out;
    logic       frame_done;

    link_rx_buffer #(.DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_in        (req_in),
        .data_in       (data_in),
        .ack_out       (ack_out),
        .last_byte_out (last_byte_out),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .level_out     (level_out),
        .byte_cnt_out  (byte_cnt_out),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued bytes, handshake phase, total captures since reset.
    logic [7:0] mq [$];
    bit         m_ack;
    logic [7:0] m_last;
    int         m_total;
    bit         m_fd;
    bit         h0, h1;

    logic [7:0] popped [$];
    int         fd_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit rq, input logic [7:0] d, input bit rr);
        bit req_eff, cap, pp;
`ifdef LINK_RX_REQ_SYNC_EN
        req_eff = h1;
`else
        req_eff = rq;
`endif
        if (r) begin
            mq.delete();
            m_ack = 0; m_last = 8'h00; m_total = 0; m_fd = 0; h0 = 0; h1 = 0;
            return;
        end
        pp  = (mq.size() > 0) && rr;
        cap = !m_ack && req_eff && (mq.size() < DEPTH);
        m_ack = m_ack ? req_eff : cap;
        if (pp) void'(mq.pop_front());
        if (cap) begin
            mq.push_back(d);
            m_last = d;
            m_total++;
            m_fd = (m_total % FL) == 0;
        end else begin
            m_fd = 0;
        end
        h1 = h0;
        h0 = rq;
    endtask

    task automatic compare_all();
        check_eq("ack", ack_out, m_ack);
        check_eq("last", last_byte_out, m_last);
        check_eq("rd_valid", rd_valid, mq.size() > 0);
        check_eq("rd_data", rd_data, (mq.size() > 0) ? mq[0] : 8'h00);
        check_eq("level", level_out, mq.size());
        check_eq("byte_cnt", byte_cnt_out, m_total % FL);
        check_eq("frame_done", frame_done, m_fd);
    endtask

    task automatic step(input bit r, input bit rq, input logic [7:0] d, input bit rr);
        rst = r; req_in = rq; data_in = d; rd_ready = rr;
        if (!r && rd_valid && rr) popped.push_back(rd_data);
        model_edge(r, rq, d, rr);
        @(negedge clk);
        if (frame_done) fd_seen++;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b, input bit rr);
        int n;
        n = 0;
        while (ack_out !== 1'b1 && n < 20) begin step(0, 1, b, rr); n++; end
        if (ack_out !== 1'b1) check_eq("ack_rise_timeout", ack_out, 1);
        n = 0;
        while (ack_out !== 1'b0 && n < 20) begin step(0, 0, b, rr); n++; end
        if (ack_out !== 1'b0) check_eq("ack_fall_timeout", ack_out, 0);
    endtask

    task automatic hold_until_ack(input logic [7:0] b);
        int n;
        n = 0;
        while (ack_out !== 1'b1 && n < 20) begin step(0, 1, b, 0); n++; end
        if (ack_out !== 1'b1) check_eq("hold_ack_timeout", ack_out, 1);
    endtask

    task automatic release_req(input bit rr);
        int n;
        n = 0;
        while (ack_out !== 1'b0 && n < 20) begin step(0, 0, 8'h00, rr); n++; end
        if (ack_out !== 1'b0) check_eq("release_timeout", ack_out, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         cur_req;
        logic [7:0] cur_dat;
        int         thr;
        logic [7:0] exp_frame [4];

        // Reset state
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        check_eq("rst_level", level_out, 0);

        // Single byte
        step(0, 0, 8'h00, 0);
        hold_until_ack(8'hA5);
        check_eq("single_last", last_byte_out, 8'hA5);
        check_eq("single_data", rd_data, 8'hA5);
        check_eq("single_level", level_out, 1);
        check_eq("single_cnt", byte_cnt_out, 1);
        release_req(0);

        // Frame with consumer always ready
        step(1, 0, 8'h00, 0);
        popped.delete();
        fd_seen = 0;
        exp_frame = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        foreach (exp_frame[i]) send(exp_frame[i], 1);
        step(0, 0, 8'h00, 1);
        check_eq("frame_pops", popped.size(), 4);
        foreach (exp_frame[i])
            check_eq("frame_order", (i < popped.size()) ? popped[i] : 8'hxx, exp_frame[i]);
        check_eq("frame_pulses", fd_seen, 1);
        check_eq("frame_cnt", byte_cnt_out, 0);

        // Backpressure
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h55, 0);
        check_eq("bp_ack", ack_out, 0);
        check_eq("bp_level", level_out, 4);
        step(0, 1, 8'h55, 1);
        check_eq("bp_pop_ack", ack_out, 0);
        check_eq("bp_pop_level", level_out, 3);
        step(0, 1, 8'h55, 0);
        check_eq("bp_late_ack", ack_out, 1);
        check_eq("bp_late_level", level_out, 4);
        release_req(0);

        // Long req
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 8'h3C, 0);
        check_eq("long_level", level_out, 1);
        check_eq("long_ack", ack_out, 1);
        release_req(0);
        check_eq("long_level_after", level_out, 1);

        // Reset mid-handshake with two queued bytes
        step(1, 0, 8'h00, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        hold_until_ack(8'h33);
        step(1, 1, 8'h33, 0);
        check_eq("mid_rst_ack", ack_out, 0);
        check_eq("mid_rst_level", level_out, 0);
        check_eq("mid_rst_last", last_byte_out, 8'h00);
        hold_until_ack(8'h33);
        check_eq("mid_recap_level", level_out, 1);
        check_eq("mid_recap_last", last_byte_out, 8'h33);
        release_req(0);

        // Random four-phase master with varying consumer duty
        step(1, 0, 8'h00, 0);
        cur_req = 0;
        cur_dat = 8'h00;
        thr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) thr = $urandom_range(5, 95);
            if (!cur_req && !ack_out && $urandom_range(0, 2) == 0) begin
                cur_req = 1;
                cur_dat = 8'($urandom);
            end else if (cur_req && ack_out && $urandom_range(0, 1) == 0) begin
                cur_req = 0;
            end
            if ($urandom_range(0, 399) == 0) step(1, cur_req, cur_dat, 0);
            else step(0, cur_req, cur_dat, $urandom_range(0, 99) < thr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
